mdu_sched: RTL

MDU_SCHED -- requirements
Module: mdu_sched

---
 rtl/mdu_sched.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/mdu_sched.sv
// mdu_sched -- multiply/divide unit scheduler with architectural HI/LO.
//
// Accepts MULT/MULTU/DIV/DIVU from the E stage when idle. It latches the
// operands and holds busy for a fixed latency of MUL_LAT or DIV_LAT cycles.
// It then writes the result to HI/LO. MTHI/MTLO write HI/LO directly when
// idle. MFHI/MFLO read them combinationally on rdata.
//
// Ports:
//   clk    in   1  clock, rising edge
//   reset  in   1  asynchronous, active-high
//   op     in   4  0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MFHI,6 MFLO,7 MTHI,8 MTLO
//   a, b   in  32  forwarded rs / rt operands
//   cancel in   1  E-stage flush (only with MDU_SCHED_CANCEL_EN defined)
//   start  out  1  combinational: mult/div accepted this cycle
//   busy   out  1  registered: mult/div in flight
//   rdata  out 32  combinational: HI for MFHI, LO for MFLO, else 0
//   hi, lo out 32  architectural HI/LO
//
// Optional feature: define MDU_SCHED_CANCEL_EN to add the cancel input.
module mdu_sched #(
   parameter int MUL_LAT = 5,
   parameter int DIV_LAT = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
`ifdef MDU_SCHED_CANCEL_EN
   input  logic        cancel,
`endif
   output logic        start,
   output logic        busy,
   output logic [31:0] rdata,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      a_q;
   logic [31:0]      b_q;
   logic             sgn_q;

   logic             kill;
   logic             is_muldiv;

`ifdef MDU_SCHED_CANCEL_EN
   assign kill = cancel;
`else
   assign kill = 1'b0;
`endif

   assign is_muldiv = (op >= 4'd1) && (op <= 4'd4);
   assign start     = is_muldiv && !busy && !kill;

   always_comb begin
      rdata = '0;
      if (op == 4'd5)      rdata = hi;
      else if (op == 4'd6) rdata = lo;
   end

   // Product from latched operands. Sign-extending to 64 bits makes the low
   // 64 bits of one multiplier correct for both signed and unsigned.
   logic [63:0] a_ext;
   logic [63:0] b_ext;
   logic [63:0] prod;

   assign a_ext = {{32{sgn_q & a_q[31]}}, a_q};
   assign b_ext = {{32{sgn_q & b_q[31]}}, b_q};
   assign prod  = a_ext * b_ext;

   // Signed divide as an unsigned divide on magnitudes, then fix the signs.
   // The quotient truncates toward zero. The remainder follows the dividend.
   logic        a_neg;
   logic        b_neg;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] q_mag;
   logic [31:0] r_mag;
   logic [31:0] quo;
   logic [31:0] rem;
   logic        div_zero;

   assign a_neg    = sgn_q & a_q[31];
   assign b_neg    = sgn_q & b_q[31];
   assign a_mag    = a_neg ? (~a_q + 32'd1) : a_q;
   assign b_mag    = b_neg ? (~b_q + 32'd1) : b_q;
   assign div_zero = (b_q == '0);

   always_comb begin
      q_mag = '0;
      r_mag = '0;
      if (!div_zero) begin
         q_mag = a_mag / b_mag;
         r_mag = a_mag % b_mag;
      end
   end

   assign quo = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
   assign rem = a_neg ? (~r_mag + 32'd1) : r_mag;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         busy  <= 1'b0;
         hi    <= '0;
         lo    <= '0;
         a_q   <= '0;
         b_q   <= '0;
         sgn_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_q   <= a;
                  b_q   <= b;
                  sgn_q <= (op == 4'd1) || (op == 4'd3);
                  busy  <= 1'b1;
                  if (op <= 4'd2) begin
                     state <= MUL;
                     cnt   <= CNT_W'(MUL_LAT);
                  end else begin
                     state <= DIV;
                     cnt   <= CNT_W'(DIV_LAT);
                  end
               end else if (!kill && op == 4'd7) begin
                  hi <= a;
               end else if (!kill && op == 4'd8) begin
                  lo <= a;
               end
            end
            MUL, DIV: begin
               // Any op arriving while busy is ignored. A cancel takes
               // priority over the final write.
               if (kill) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  cnt   <= '0;
               end else if (cnt == CNT_W'(1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  cnt   <= '0;
                  if (state == MUL) begin
                     hi <= prod[63:32];
                     lo <= prod[31:0];
                  end else if (!div_zero) begin
                     hi <= rem;
                     lo <= quo;
                  end
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule
